// File: rtl/sd_card_pkg.sv
// sd_card_pkg: shared encodings for the SD SPI-mode receive path
package sd_card_pkg;
    typedef enum logic [1:0] {
        MODE_R1          = 2'd0,
        MODE_DATA_RESP   = 2'd1,
        MODE_START_TOKEN = 2'd2,
        MODE_RSVD        = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_TIMEOUT      = 3'd1,
        ST_CRC_REJECT   = 3'd2,
        ST_WRITE_REJECT = 3'd3,
        ST_BAD_RESP     = 3'd4,
        ST_BUSY_TIMEOUT = 3'd5
    } status_t;

    typedef enum logic [2:0] {S_IDLE, S_HUNT, S_SHIFT, S_BUSY, S_DONE} state_t;

    localparam logic [7:0] TOK_START    = 8'hFE;
    localparam logic [2:0] DRESP_ACCEPT = 3'b010;
    localparam logic [2:0] DRESP_CRC    = 3'b101;
    localparam logic [2:0] DRESP_WRERR  = 3'b110;

    // ST_OK here means "accepted, card busy phase follows"
    function automatic status_t dresp_status(input logic [7:0] f);
        if (f[4] || !f[0]) return ST_BAD_RESP;
        return f[3:1] == DRESP_ACCEPT ? ST_OK :
               f[3:1] == DRESP_CRC    ? ST_CRC_REJECT :
               f[3:1] == DRESP_WRERR  ? ST_WRITE_REJECT : ST_BAD_RESP;
    endfunction
endpackage

// File: rtl/sd_card_bit_window.sv
// sd_card_bit_window: last 8 sampled DO bits, newest in bit 0, idles at all-ones
module sd_card_bit_window (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_window
);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) o_window <= 8'hFF;
        else if (i_en) o_window <= {o_window[6:0], i_bit};
    end
endmodule

// File: rtl/sd_card_resp_rx.sv
// sd_card_resp_rx: decodes R1, data-response (+busy) and start-block tokens from SD DO
module sd_card_resp_rx
    import sd_card_pkg::*;
#(
    parameter int NCR_MAX  = 16,
    parameter int NAC_MAX  = 8192,
    parameter int BUSY_MAX = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sd_DO,
    input  logic       i_bit_en,
    input  logic       i_arm,
    input  logic [1:0] i_mode,
    output logic [7:0] o_accept_register,
    output logic [7:0] o_byte,
    output logic [2:0] o_data_resp,
    output logic       o_card_busy,
    output logic       o_active,
    output logic       o_done,
    output logic [2:0] o_status
);
    localparam int NCR_W  = $clog2(NCR_MAX) + 1;
    localparam int NAC_W  = $clog2(NAC_MAX) + 1;
    localparam int BUSY_W = $clog2(BUSY_MAX) + 1;

    state_t              state;
    mode_t               mode;
    logic [NCR_W-1:0]    ncr_cnt;
    logic [NAC_W-1:0]    nac_cnt;
    logic [BUSY_W-1:0]   busy_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          frame, frame_nxt, win_nxt;
    logic                fin, accept, err_tok;
    status_t             fin_st;

    sd_card_bit_window u_win (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (i_bit_en),
        .i_bit    (i_sd_DO),
        .o_window (o_accept_register)
    );

    assign win_nxt   = {o_accept_register[6:0], i_sd_DO};
    assign frame_nxt = {frame[6:0], i_sd_DO};
    assign err_tok   = win_nxt[7:4] == 4'h0 && o_accept_register == 8'hFF;
    assign accept    = mode == MODE_DATA_RESP && dresp_status(frame_nxt) == ST_OK;

    // fin marks the strobe that ends the request; fin_st is the status it reports
    always_comb begin
        fin    = 1'b0;
        fin_st = ST_OK;
        if (i_bit_en) begin
            case (state)
                S_HUNT: begin
                    if (mode == MODE_START_TOKEN) begin
                        fin    = win_nxt == TOK_START || err_tok || nac_cnt + 1'b1 == NAC_W'(NAC_MAX);
                        fin_st = win_nxt == TOK_START ? ST_OK : err_tok ? ST_BAD_RESP : ST_TIMEOUT;
                    end else begin
                        fin    = i_sd_DO && ncr_cnt + 1'b1 == NCR_W'(NCR_MAX);
                        fin_st = ST_TIMEOUT;
                    end
                end
                S_SHIFT: begin
                    fin    = bit_cnt == 3'd7 && !accept;
                    fin_st = mode == MODE_R1 ? ST_OK : dresp_status(frame_nxt);
                end
                S_BUSY: begin
                    fin    = i_sd_DO || busy_cnt + 1'b1 == BUSY_W'(BUSY_MAX);
                    fin_st = i_sd_DO ? ST_OK : ST_BUSY_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            mode        <= MODE_R1;
            ncr_cnt     <= '0;
            nac_cnt     <= '0;
            busy_cnt    <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            o_byte      <= 8'hFF;
            o_data_resp <= '0;
            o_status    <= '0;
            o_card_busy <= 1'b0;
            o_active    <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: if (i_arm && i_mode != MODE_RSVD) begin
                    mode     <= mode_t'(i_mode);
                    ncr_cnt  <= '0;
                    nac_cnt  <= '0;
                    busy_cnt <= '0;
                    bit_cnt  <= '0;
                    o_active <= 1'b1;
                    state    <= S_HUNT;
                end
                S_HUNT: if (i_bit_en) begin
                    if (mode == MODE_START_TOKEN) begin
                        nac_cnt <= nac_cnt == NAC_W'(NAC_MAX) ? nac_cnt : nac_cnt + 1'b1;
                        if (win_nxt == TOK_START || err_tok) o_byte <= win_nxt;
                    end else if (i_sd_DO) begin
                        ncr_cnt <= ncr_cnt == NCR_W'(NCR_MAX) ? ncr_cnt : ncr_cnt + 1'b1;
                    end else begin
                        frame   <= '0;
                        bit_cnt <= 3'd1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: if (i_bit_en) begin
                    frame   <= frame_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        o_byte <= frame_nxt;
                        if (mode == MODE_DATA_RESP) o_data_resp <= frame_nxt[3:1];
                        if (accept) begin
                            o_card_busy <= 1'b1;
                            state       <= S_BUSY;
                        end
                    end
                end
                S_BUSY: if (i_bit_en && !i_sd_DO)
                    busy_cnt <= busy_cnt == BUSY_W'(BUSY_MAX) ? busy_cnt : busy_cnt + 1'b1;
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (fin) begin
                state       <= S_DONE;
                o_done      <= 1'b1;
                o_active    <= 1'b0;
                o_card_busy <= 1'b0;
                o_status    <= fin_st;
            end
        end
    end
endmodule

// File: tb/tb_sd_card_resp_rx.sv
// tb_sd_card_resp_rx: randomized scoreboard bench for the SD response receiver
module tb_sd_card_resp_rx;
    localparam int NCR_MAX  = 16;
    localparam int NAC_MAX  = 8192;
    localparam int BUSY_MAX = 64;

    logic       i_clk = 1'b0, i_rst_n = 1'b0, i_sd_DO = 1'b1, i_bit_en = 1'b0, i_arm = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic [7:0] o_accept_register, o_byte;
    logic [2:0] o_data_resp, o_status;
    logic       o_card_busy, o_active, o_done;

    always #5 i_clk = ~i_clk;

    sd_card_resp_rx #(.NCR_MAX(NCR_MAX), .NAC_MAX(NAC_MAX), .BUSY_MAX(BUSY_MAX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sd_DO(i_sd_DO), .i_bit_en(i_bit_en),
        .i_arm(i_arm), .i_mode(i_mode), .o_accept_register(o_accept_register),
        .o_byte(o_byte), .o_data_resp(o_data_resp), .o_card_busy(o_card_busy),
        .o_active(o_active), .o_done(o_done), .o_status(o_status)
    );

    typedef struct {int st; int byt; int dr; int bz; int n; int lat; bit cb; bit cd;} exp_t;
    exp_t       exp_q[$];
    bit         b[$];
    logic [7:0] tb_win = 8'hFF, mon_win = 8'hFF;
    int n_cmp = 0, n_err = 0, cyc = 0, done_cnt = 0, strobe_n = 0, busy_n = 0, last_strobe = 0, arm_cyc = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic bit get(input int i);
        return i < b.size() ? b[i] : 1'b1;
    endfunction

    // Reference: scan the planned DO stream for the frame/token the request should find
    function automatic exp_t model(input int m, input logic [7:0] w0);
        exp_t e;
        int i;
        logic [7:0] f, w, p;
        e = '{default: 0};
        if (m == 2) begin
            w = w0; e.st = 1; e.n = NAC_MAX;
            for (int k = 0; k < NAC_MAX; k++) begin
                p = w; w = {w[6:0], get(k)};
                if (w == 8'hFE) begin e.st = 0; e.byt = 8'hFE; e.cb = 1; e.n = k + 1; break; end
                if (w[7:4] == 4'h0 && p == 8'hFF) begin e.st = 4; e.byt = w; e.cb = 1; e.n = k + 1; break; end
            end
            return e;
        end
        i = 0;
        while (i < NCR_MAX && get(i)) i++;
        if (i == NCR_MAX) begin e.st = 1; e.n = NCR_MAX; return e; end
        for (int k = 0; k < 8; k++) f[7-k] = get(i + k);
        e.n = i + 8; e.byt = f; e.cb = 1;
        if (m == 0) return e;
        e.dr = int'(f[3:1]); e.cd = 1;
        if (f[4] || !f[0]) e.st = 4;
        else if (f[3:1] == 3'b101) e.st = 2;
        else if (f[3:1] == 3'b110) e.st = 3;
        else if (f[3:1] != 3'b010) e.st = 4;
        else begin
            i = e.n;
            while (i - e.n < BUSY_MAX && !get(i)) i++;
            e.bz = i - e.n;
            e.st = e.bz == BUSY_MAX ? 5 : 0;
            e.n  = e.bz == BUSY_MAX ? i : i + 1;
        end
        return e;
    endfunction

    initial forever begin
        exp_t e;
        @(negedge i_clk);
        cyc++;
        if (o_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("status", int'(o_status), e.st);
                if (e.cb) chk("byte", int'(o_byte), e.byt);
                if (e.cd) chk("data_resp", int'(o_data_resp), e.dr);
                chk("busy_strobes", busy_n, e.bz);
                chk("strobes", strobe_n, e.n);
                chk("done_latency", cyc - last_strobe, 1);
                if (e.lat > 0) chk("arm_to_done", cyc - arm_cyc, e.lat);
                chk("window", int'(o_accept_register), int'(mon_win));
                chk("active_at_done", int'(o_active), 0);
            end
            done_cnt++;
        end
        if (i_rst_n && i_bit_en && o_active) begin strobe_n++; last_strobe = cyc; end
        if (i_rst_n && i_bit_en && o_card_busy && !i_sd_DO) busy_n++;
        if (i_rst_n && i_arm && i_mode != 2'd3 && !o_active && !o_done) begin
            strobe_n = 0; busy_n = 0; arm_cyc = cyc;
        end
        if (!i_rst_n) mon_win = 8'hFF;
        else if (i_bit_en) mon_win = {mon_win[6:0], i_sd_DO};
    end

    task automatic cyc_in(input bit be, input bit d, input bit arm, input logic [1:0] md);
        @(posedge i_clk); #1;
        i_bit_en = be; i_sd_DO = d; i_arm = arm; i_mode = md;
        if (be) tb_win = {tb_win[6:0], d};
    endtask

    task automatic push_bits(input int v, input int nb);
        for (int k = nb - 1; k >= 0; k--) b.push_back(1'((v >> k) & 1));
    endtask

    task automatic push_rep(input bit v, input int k);
        repeat (k) b.push_back(v);
    endtask

    // gap < 0: random 0..2 idle cycles before each strobe; stray arms in gaps must be ignored
    task automatic run_req(input int m, input int gap, input bit chk_lat);
        exp_t e;
        int g, d0;
        if ($urandom_range(0, 4) == 0) begin
            cyc_in(0, 1'b1, 1'b1, 2'd3);
            cyc_in(0, 1'b1, 1'b0, 2'd0);
            @(negedge i_clk);
            chk("mode3_ignored", int'(o_active), 0);
        end
        repeat ($urandom_range(0, 3)) cyc_in(1'b1, 1'($urandom), 1'b0, 2'd0);
        cyc_in(gap < 0 ? 1'($urandom) : 1'b0, 1'($urandom), 1'b1, 2'(m));
        e = model(m, tb_win);
        e.lat = chk_lat ? e.n * (gap + 1) + 1 : 0;
        exp_q.push_back(e);
        d0 = done_cnt;
        for (int i = 0; i < e.n; i++) begin
            g = gap < 0 ? $urandom_range(0, 2) : gap;
            repeat (g) cyc_in(1'b0, 1'($urandom), $urandom_range(0, 7) == 0, 2'($urandom));
            cyc_in(1'b1, get(i), 1'b0, 2'd0);
        end
        cyc_in(1'b0, 1'b1, 1'b0, 2'd0);
        for (int t = 0; t < 10 && done_cnt == d0; t++) @(posedge i_clk);
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic reset_mid_busy();
        int d0;
        b = {};
        push_rep(1'b1, 2); push_bits(8'h05, 8); push_rep(1'b0, 10);
        cyc_in(1'b0, 1'b1, 1'b1, 2'd1);
        d0 = done_cnt;
        foreach (b[i]) cyc_in(1'b1, b[i], 1'b0, 2'd0);
        cyc_in(1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge i_clk);
        chk("busy_before_reset", int'(o_card_busy), 1);
        @(posedge i_clk); #1 i_rst_n = 1'b0;
        @(posedge i_clk); #1 i_rst_n = 1'b1; tb_win = 8'hFF;
        @(negedge i_clk);
        chk("rst_busy", int'(o_card_busy), 0);
        chk("rst_active", int'(o_active), 0);
        chk("rst_window", int'(o_accept_register), 8'hFF);
        repeat (3) @(posedge i_clk);
        chk("rst_no_done", done_cnt - d0, 0);
    endtask

    initial begin
        int m, k, z, f;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_window", int'(o_accept_register), 8'hFF);
        chk("rst_byte", int'(o_byte), 8'hFF);
        chk("rst_status", int'(o_status), 0);
        chk("rst_data_resp", int'(o_data_resp), 0);
        chk("rst_flags", int'({o_card_busy, o_active, o_done}), 0);
        @(posedge i_clk); #1 i_rst_n = 1'b1;

        b = {}; push_rep(1'b1, 2); push_bits(8'h00, 8);
        run_req(0, 0, 1'b1);
        b = {}; push_rep(1'b1, 2); push_bits(8'h05, 8); push_rep(1'b0, 20); push_rep(1'b1, 1);
        run_req(1, 0, 1'b1);
        b = {}; push_rep(1'b1, 2); push_bits(8'h0B, 8);
        run_req(1, 0, 1'b1);
        b = {}; push_rep(1'b1, 300); push_bits(8'hFE, 8);
        run_req(2, 0, 1'b1);
        b = {};
        run_req(2, 0, 1'b1);
        run_req(0, 0, 1'b1);
        run_req(0, 3, 1'b1);
        b = {}; push_rep(1'b1, 1); push_bits(8'h05, 8); push_rep(1'b0, BUSY_MAX + 4);
        run_req(1, 0, 1'b1);
        reset_mid_busy();
        b = {}; push_rep(1'b1, 3); push_bits(8'h2A, 8);
        run_req(0, 0, 1'b1);

        repeat (40) begin
            m = $urandom_range(0, 2);
            b = {};
            if (m == 0) begin
                push_rep(1'b1, $urandom_range(0, 20));
                push_bits($urandom_range(0, 127), 8);
            end else if (m == 1) begin
                push_rep(1'b1, $urandom_range(0, 18));
                k = $urandom_range(0, 3);
                f = (($urandom_range(0, 3)) << 5) | (k == 0 ? 3'b010 : k == 1 ? 3'b101 : k == 2 ? 3'b110 : $urandom_range(0, 7)) << 1 | 1;
                if ($urandom_range(0, 7) == 0) f = f ^ 8'h10;
                if ($urandom_range(0, 7) == 0) f = f ^ 8'h01;
                push_bits(f, 8);
                z = $urandom_range(0, 5) == 0 ? BUSY_MAX + 3 : $urandom_range(0, 30);
                push_rep(1'b0, z); push_rep(1'b1, 1);
            end else begin
                push_rep(1'b1, $urandom_range(0, 300));
                if ($urandom_range(0, 1) == 1) repeat (30) b.push_back(1'($urandom));
                push_bits(8'hFE, 8);
            end
            run_req(m, $urandom_range(0, 1) == 1 ? -1 : 0, 1'b0);
        end
        repeat (4) @(posedge i_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of run, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
